// File: rtl/dram_bist_if.sv
// Wishbone-style bus between the BIST engine and the DRAM wrapper's user-side
// slave port.
//   cyc_o / stb_o / we_o : cycle, strobe, write enable (master -> slave)
//   addr_o               : byte address {word_index, 7'h0}
//   data_o               : write data (master -> slave)
//   data_i               : read data, valid while ack_i = 1 (slave -> master)
//   ack_i                : transaction complete (slave -> master)
interface dram_bist_if #(
    parameter int WORD_SIZE = 256
);
    logic                 cyc_o;
    logic                 stb_o;
    logic                 we_o;
    logic [31:0]          addr_o;
    logic [WORD_SIZE-1:0] data_o;
    logic [WORD_SIZE-1:0] data_i;
    logic                 ack_i;

    modport master (
        output cyc_o, stb_o, we_o, addr_o, data_o,
        input  data_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, addr_o, data_o,
        output data_i, ack_i
    );
endinterface

// File: rtl/dram_bist.sv
// DRAM built-in self-test engine. After the wrapper reports initialized, each
// of nine data patterns gets a full write pass over word indices
// 0..NUM_WORDS-1 followed by a full read-back-and-compare pass. Results are
// held for LEDs/debug until the next start or reset.
//   sys_clk, rst         : clock, asynchronous active-high reset
//   start                : one-cycle pulse, begins a run (ignored while busy)
//   initialized          : wrapper calibration done
//   bus                  : Wishbone-style master port to the wrapper
//   busy, done           : run in progress / run finished (sticky)
//   pass, fail, timeout  : run verdict; timeout = aborted waiting for ack
//   error_count          : mismatching words, saturating
//   first_err_addr       : word index of the first mismatch
//   pattern_idx          : pattern under test (0..8)
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no run since reset
// WAIT_INIT | run requested, waiting for wrapper calibration
// WR_REQ    | turnaround gap after a write ack, issues next write
// WR_WAIT   | write strobed, waiting for ack
// RD_REQ    | turnaround gap after the last write, issues first read
// RD_WAIT   | read strobed, waiting for ack
// CHECK     | compare captured word; this cycle is also the turnaround gap
// DONE      | results valid and held
module dram_bist #(
    parameter int WORD_SIZE      = 256,
    parameter int ADDR_WIDTH     = 25,
    parameter int NUM_WORDS      = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  initialized,
    dram_bist_if.master           bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [15:0]           error_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [3:0]            pattern_idx
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_INIT, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  index, index_nxt;
    logic [TW-1:0]          tmo_cnt, tmo_nxt;
    logic [WORD_SIZE-1:0]   rd_data, rd_nxt;
    logic                   cyc, cyc_nxt, stb, stb_nxt, we, we_nxt;
    logic [31:0]            addr, addr_nxt;
    logic [WORD_SIZE-1:0]   wdata, wdata_nxt;
    logic                   busy_nxt, done_nxt, pass_nxt, fail_nxt, timeout_nxt;
    logic [15:0]            err_nxt;
    logic [ADDR_WIDTH-1:0]  first_nxt;
    logic [3:0]             pidx_nxt;
    logic [WORD_SIZE-1:0]   exp_word;

    // Patterns 0..7 replicate one byte; pattern 8 puts (index + lane) in each
    // 32-bit lane so address aliasing shows up as a data mismatch.
    function automatic logic [WORD_SIZE-1:0] pattern_word(
        input logic [3:0] p, input logic [ADDR_WIDTH-1:0] idx);
        logic [7:0]           b;
        logic [WORD_SIZE-1:0] w;
        case (p)
            4'd0:    b = 8'hA5;
            4'd1:    b = 8'h5A;
            4'd2:    b = 8'hFF;
            4'd3:    b = 8'h00;
            4'd4:    b = 8'hF0;
            4'd5:    b = 8'h0F;
            4'd6:    b = 8'hAA;
            4'd7:    b = 8'h55;
            default: b = 8'h00;
        endcase
        w = {(WORD_SIZE/8){b}};
        if (p == 4'd8) begin
            for (int k = 0; k < WORD_SIZE/32; k++)
                w[k*32 +: 32] = 32'(idx) + 32'(k);
        end
        return w;
    endfunction

    function automatic logic [31:0] byte_addr(input logic [ADDR_WIDTH-1:0] idx);
        return 32'({idx, 7'h0});
    endfunction

    assign bus.cyc_o  = cyc;
    assign bus.stb_o  = stb;
    assign bus.we_o   = we;
    assign bus.addr_o = addr;
    assign bus.data_o = wdata;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            index          <= '0;
            tmo_cnt        <= '0;
            rd_data        <= '0;
            cyc            <= 1'b0;
            stb            <= 1'b0;
            we             <= 1'b0;
            addr           <= '0;
            wdata          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
            pattern_idx    <= '0;
        end else begin
            state          <= state_nxt;
            index          <= index_nxt;
            tmo_cnt        <= tmo_nxt;
            rd_data        <= rd_nxt;
            cyc            <= cyc_nxt;
            stb            <= stb_nxt;
            we             <= we_nxt;
            addr           <= addr_nxt;
            wdata          <= wdata_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            fail           <= fail_nxt;
            timeout        <= timeout_nxt;
            error_count    <= err_nxt;
            first_err_addr <= first_nxt;
            pattern_idx    <= pidx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        index_nxt   = index;
        tmo_nxt     = tmo_cnt;
        rd_nxt      = rd_data;
        cyc_nxt     = cyc;
        stb_nxt     = stb;
        we_nxt      = we;
        addr_nxt    = addr;
        wdata_nxt   = wdata;
        busy_nxt    = busy;
        done_nxt    = done;
        pass_nxt    = pass;
        fail_nxt    = fail;
        timeout_nxt = timeout;
        err_nxt     = error_count;
        first_nxt   = first_err_addr;
        pidx_nxt    = pattern_idx;
        exp_word    = pattern_word(pattern_idx, index);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    busy_nxt    = 1'b1;
                    done_nxt    = 1'b0;
                    pass_nxt    = 1'b0;
                    fail_nxt    = 1'b0;
                    timeout_nxt = 1'b0;
                    err_nxt     = '0;
                    first_nxt   = '0;
                    pidx_nxt    = '0;
                    index_nxt   = '0;
                    state_nxt   = WAIT_INIT;
                end
            end
            WAIT_INIT, WR_REQ: begin
                if (state == WR_REQ || initialized) begin
                    cyc_nxt   = 1'b1;
                    stb_nxt   = 1'b1;
                    we_nxt    = 1'b1;
                    addr_nxt  = byte_addr(index);
                    wdata_nxt = exp_word;
                    tmo_nxt   = '0;
                    state_nxt = WR_WAIT;
                end
            end
            RD_REQ: begin
                cyc_nxt   = 1'b1;
                stb_nxt   = 1'b1;
                we_nxt    = 1'b0;
                addr_nxt  = byte_addr(index);
                tmo_nxt   = '0;
                state_nxt = RD_WAIT;
            end
            WR_WAIT, RD_WAIT: begin
                if (bus.ack_i) begin
                    cyc_nxt = 1'b0;
                    stb_nxt = 1'b0;
                    if (state == RD_WAIT) begin
                        rd_nxt    = bus.data_i;
                        state_nxt = CHECK;
                    end else if (index != LAST_IDX) begin
                        index_nxt = index + ADDR_WIDTH'(1);
                        state_nxt = WR_REQ;
                    end else begin
                        index_nxt = '0;
                        state_nxt = RD_REQ;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    cyc_nxt     = 1'b0;
                    stb_nxt     = 1'b0;
                    timeout_nxt = 1'b1;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    pass_nxt    = 1'b0;
                    fail_nxt    = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    tmo_nxt = tmo_cnt + TW'(1);
                end
            end
            CHECK: begin
                if (rd_data != exp_word) begin
                    if (error_count != 16'hFFFF)
                        err_nxt = error_count + 16'd1;
                    if (error_count == 16'd0)
                        first_nxt = index;
                end
                // The compare cycle already has cyc low, so the next request
                // is launched from here to keep the bus gap at one cycle.
                tmo_nxt = '0;
                if (index != LAST_IDX) begin
                    index_nxt = index + ADDR_WIDTH'(1);
                    cyc_nxt   = 1'b1;
                    stb_nxt   = 1'b1;
                    we_nxt    = 1'b0;
                    addr_nxt  = byte_addr(index_nxt);
                    state_nxt = RD_WAIT;
                end else if (pattern_idx != 4'd8) begin
                    pidx_nxt  = pattern_idx + 4'd1;
                    index_nxt = '0;
                    cyc_nxt   = 1'b1;
                    stb_nxt   = 1'b1;
                    we_nxt    = 1'b1;
                    addr_nxt  = byte_addr('0);
                    wdata_nxt = pattern_word(pidx_nxt, '0);
                    state_nxt = WR_WAIT;
                end else begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_nxt == 16'd0);
                    fail_nxt  = (err_nxt != 16'd0);
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
